// File: rtl/finalsoc_key_pio_edge.sv
// finalsoc_key_pio_edge
//
// Key/button parallel-input peripheral with an Avalon-MM slave port.
// Each input channel is synchronized, optionally debounced, and edge
// detected. Detected edges latch into edge_capture, which raises irq
// when the matching irq_mask bit is set.
//
// Build option:
//   FINALSOC_KEY_PIO_DEBOUNCE_EN  defined   -> per-channel debounce counters
//                                 undefined -> no counters; the debounced
//                                              register follows the
//                                              synchronizer directly
//
// Register map (word address):
//   0  data          debounced input value (read-only)
//   1  reserved      reads 0, writes ignored
//   2  irq_mask      read/write, bits [WIDTH-1:0]
//   3  edge_capture  read, write-1-to-clear (a new edge wins over a clear)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   address     word address
//   chipselect  qualifies a write
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous key inputs, WIDTH channels
//   readdata    addressed register, registered, zero-extended
//   irq         level interrupt, active-high, registered

module finalsoc_key_pio_edge #(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               EDGE_MODE       = 1,
    parameter logic [WIDTH-1:0] IN_RESET_VAL    = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      rd_next;
    logic             unused_bits;

    assign wr_en = chipselect & ~write_n;

    // Only writedata[WIDTH-1:0] is meaningful; DEBOUNCE_CYCLES is not
    // referenced when the debounce counters are compiled out.
    assign unused_bits = (^writedata) ^ (DEBOUNCE_CYCLES == 0);

`ifdef FINALSOC_KEY_PIO_DEBOUNCE_EN

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter only ever reaches DEBOUNCE_CYCLES-1: the mismatching
    // cycle that would make it DEBOUNCE_CYCLES loads deb and clears
    // instead, so the count can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IN_RESET_VAL;
            sync2 <= IN_RESET_VAL;
            deb   <= IN_RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`else

    // Without debounce the debounced register doubles as the second
    // synchronizer stage, keeping in_port-to-readdata latency at 3 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IN_RESET_VAL;
            deb   <= IN_RESET_VAL;
        end else begin
            sync1 <= in_port;
            deb   <= sync1;
        end
    end

`endif

    always_comb begin
        edges = '0;
        if (EDGE_MODE == 0) begin
            edges = deb & ~deb_d;
        end else if (EDGE_MODE == 2) begin
            edges = deb ^ deb_d;
        end else begin
            edges = ~deb & deb_d;
        end
    end

    always_comb begin
        clr_mask = '0;
        if (wr_en && address == 2'd3) begin
            clr_mask = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = deb;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    // deb_d reloads IN_RESET_VAL alongside deb so leaving reset never
    // looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d        <= IN_RESET_VAL;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            deb_d <= deb;
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // Set wins over a simultaneous write-1-to-clear.
            edge_capture <= (edge_capture & ~clr_mask) | edges;
            readdata     <= rd_next;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_finalsoc_key_pio_edge.sv
// Testbench for finalsoc_key_pio_edge (WIDTH=4, DEBOUNCE_CYCLES=4,
// EDGE_MODE=1 falling, IN_RESET_VAL=4'hF). A driver issues one bus/input
// cycle at a time, advances a behavioural model and queues the expected
// readdata/irq seen after that clock edge; a monitor pops and compares.
// The model treats debounce as "the synchronized input has held the
// opposite value for N consecutive samples", using a history of inputs.

module tb_finalsoc_key_pio_edge;

    localparam int DC = 4;
`ifdef FINALSOC_KEY_PIO_DEBOUNCE_EN
    localparam int LAT = 2;   // synchronizer depth ahead of the debounce window
    localparam int NWIN = DC;
`else
    localparam int LAT = 1;
    localparam int NWIN = 1;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    finalsoc_key_pio_edge #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_MODE(1),
        .IN_RESET_VAL(4'hF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          target;
        logic [31:0] rd;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // model state
    logic [3:0] hist[$];
    logic [3:0] deb_m  = 4'hF;
    logic [3:0] debd_m = 4'hF;
    logic [3:0] mask_m = 4'h0;
    logic [3:0] ec_m   = 4'h0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].target <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (readdata !== e.rd) begin
                errors++;
                $display("FAIL %s readdata cycle %0d: got %h expected %h", e.tag, cyc, readdata, e.rd);
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL %s irq cycle %0d: got %b expected %b", e.tag, cyc, irq, e.irq);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] inp, input logic [1:0] addr,
                        input logic wr, input logic [31:0] wd, input string tag);
        exp_t e;
        logic [3:0] nd;
        logic [3:0] clr;
        int sel;
        reset     = r;
        in_port   = inp;
        address   = addr;
        writedata = wd;
        if (wr) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else begin
            sel = $urandom_range(0, 2);
            chipselect = (sel == 0);
            write_n    = (sel != 2);
        end

        e.target = cyc + 1;
        e.tag    = tag;
        e.rd     = '0;
        case (addr)
            2'd0: e.rd[3:0] = deb_m;
            2'd2: e.rd[3:0] = mask_m;
            2'd3: e.rd[3:0] = ec_m;
            default: e.rd = '0;
        endcase
        e.irq = |(ec_m & mask_m);
        if (r) begin
            e.rd  = '0;
            e.irq = 1'b0;
        end
        sb.push_back(e);

        if (r) begin
            hist.push_back(4'hF);
            deb_m  = 4'hF;
            debd_m = 4'hF;
            mask_m = 4'h0;
            ec_m   = 4'h0;
        end else begin
            hist.push_back(inp);
            nd = deb_m;
            for (int b = 0; b < 4; b++) begin
                bit flip;
                logic [3:0] v;
                flip = 1'b1;
                for (int j = 0; j < NWIN; j++) begin
                    v = hist[hist.size() - 1 - LAT - j];
                    if (v[b] == deb_m[b]) flip = 1'b0;
                end
                if (flip) nd[b] = ~deb_m[b];
            end
            clr = (wr && addr == 2'd3) ? wd[3:0] : 4'h0;
            ec_m = (ec_m & ~clr) | (debd_m & ~deb_m);
            if (wr && addr == 2'd2) mask_m = wd[3:0];
            debd_m = deb_m;
            deb_m  = nd;
        end
        if (hist.size() > 32) void'(hist.pop_front());

        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] inp, input logic [1:0] addr, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, inp, addr, 1'b0, $urandom, tag);
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] inp;
        logic [3:0] gm;
        int hcnt;
        bit done;

        for (int i = 0; i < 16; i++) hist.push_back(4'hF);

        // reset state
        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 2'(i), 1'b0, 32'h0, "reset");
        step(1'b0, 4'hF, 2'd0, 1'b0, 32'h0, "post_reset_a0");
        step(1'b0, 4'hF, 2'd2, 1'b0, 32'h0, "post_reset_a2");
        step(1'b0, 4'hF, 2'd3, 1'b0, 32'h0, "post_reset_a3");
        step(1'b0, 4'hF, 2'd1, 1'b0, 32'h0, "post_reset_a1");
        step(1'b0, 4'hF, 2'd0, 1'b0, 32'h0, "post_reset_a0b");

        // latency of a held change on bit0, then capture
        hold(4'hE, 2'd0, 10, "latency_data");
        hold(4'hE, 2'd3, 2, "latency_capture");
        step(1'b0, 4'hE, 2'd3, 1'b1, 32'h1, "clear_bit0");
        hold(4'hF, 2'd3, 10, "rise_no_capture");
        hold(4'hF, 2'd0, 2, "rise_data");

        // short glitch on bit0 must be ignored
        hold(4'hE, 2'd0, DC - 1, "glitch");
        hold(4'hF, 2'd0, 8, "glitch_data");
        hold(4'hF, 2'd3, 2, "glitch_capture");

        // interrupt assert and clear
        step(1'b0, 4'hF, 2'd2, 1'b1, 32'h1, "mask_write");
        hold(4'hE, 2'd3, 10, "irq_assert");
        step(1'b0, 4'hE, 2'd3, 1'b1, 32'h1, "irq_clear");
        hold(4'hE, 2'd3, 3, "irq_deassert");

        // clear of bit1 in the same cycle its edge is captured
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (((debd_m & ~deb_m) & 4'h2) != 4'h0) begin
                step(1'b0, 4'hC, 2'd3, 1'b1, 32'h2, "set_wins_write");
                done = 1'b1;
            end else begin
                step(1'b0, 4'hC, 2'd3, 1'b0, 32'h0, "set_wins_wait");
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL set_wins_edge: got none expected bit1 edge within 20 cycles");
        end
        hold(4'hC, 2'd3, 3, "set_wins_read");

        // randomized traffic including occasional mid-debounce resets
        cur  = 4'hC;
        hcnt = 0;
        for (int i = 0; i < 1500; i++) begin
            logic r;
            logic wr;
            if (hcnt == 0) begin
                cur  = 4'($urandom);
                hcnt = $urandom_range(1, 12);
            end
            hcnt--;
            inp = cur;
            if ($urandom_range(0, 15) == 0) begin
                gm  = 4'b0001 << $urandom_range(0, 3);
                inp = cur ^ gm;
            end
            r  = ($urandom_range(0, 199) == 0);
            wr = ($urandom_range(0, 3) == 0);
            step(r, inp, 2'($urandom), wr, $urandom, "random");
        end

        hold(4'hF, 2'd0, 3, "drain");
        #20;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/finalsoc_key_pio_edge.md
FINALSOC_KEY_PIO_EDGE -- requirements
Module: finalsoc_key_pio_edge

Interface
REQ-001 Parameter WIDTH, default 2, number of input channels; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, stable-cycle count required before a channel's debounced value changes; legal range 1..65535.
REQ-003 Parameter EDGE_MODE, default 1, selects capture: 0 rising, 1 falling, 2 any edge.
REQ-004 Parameter IN_RESET_VAL, default all-ones, reset value of synchronizer and debounced registers.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 address  input  2  Avalon slave word address.
REQ-008 chipselect  input  1  qualifies write.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous key inputs.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer per channel before any other use.
REQ-015 Per channel, a counter SHALL clear whenever synchronized value equals debounced value, else increment; on reaching DEBOUNCE_CYCLES the debounced bit SHALL take the synchronized value and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced value.
REQ-017 Edge detect SHALL compare debounced value against its 1-cycle-delayed copy; a qualifying edge per EDGE_MODE SHALL set that channel's edge_capture bit next cycle.
REQ-018 Register map (word address): 0 data = debounced value, read-only; 2 irq_mask, read/write, bits [WIDTH-1:0]; 3 edge_capture, read, write-1-to-clear; address 1 reads 0, writes ignored.
REQ-019 Write occurs when chipselect=1 and write_n=0; takes effect on the next clock edge.
REQ-020 edge_capture bit written 1 in the same cycle a new edge is detected for that bit SHALL remain set (set wins).
REQ-021 readdata SHALL update every cycle with the addressed register, zero-extended to 32 bits; read latency 1 cycle.
REQ-022 irq SHALL be registered OR-reduce of (edge_capture AND irq_mask); asserts 1 cycle after capture bit sets, deasserts 1 cycle after clear or mask.
REQ-023 Total latency in_port change to data register SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-024 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)); counter SHALL never wrap.

Reset
REQ-025 While reset=1 on a clock edge: synchronizers, debounced and delayed-debounced registers SHALL load IN_RESET_VAL; counters, irq_mask, edge_capture, readdata, irq SHALL load 0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; no edge SHALL be captured from the reset transition itself.

Configuration
REQ-027 Macro FINALSOC_KEY_PIO_DEBOUNCE_EN defined: debounce per REQ-015/016 compiled in.
REQ-028 Macro undefined: counters omitted; debounced register SHALL load synchronized value every cycle; latency becomes 3 cycles; DEBOUNCE_CYCLES ignored.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=1, IN_RESET_VAL=4'hF, macro defined)
REQ-029 Reset, read addr 0/2/3 -> readdata 0x0000000F, 0x0, 0x0; irq=0.
REQ-030 in_port 4'hF->4'hE held -> addr 0 reads 0xE exactly 7 cycles after change; edge_capture reads 0x1.
REQ-031 in_port bit0 low for 3 cycles then high -> data stays 0xF, edge_capture stays 0.
REQ-032 irq_mask=0x1, bit0 falling edge -> irq=1; write 0x1 to addr 3 -> irq=0 two cycles later.
REQ-033 Write 0x2 to addr 3 in same cycle bit1 edge is captured -> edge_capture bit1 remains 1.
REQ-034 Macro undefined, in_port 4'hF->4'h7 -> addr 0 reads 0x7 after 3 cycles; edge_capture 0x8.
